// File: rtl/pnode_tagger_pkg.sv
// Shared definitions for the pnode tagger: field layout of the tagged beat,
// counter widths, packet FSM states and small helpers.
package pnode_tagger_pkg;

  localparam int DATA_WIDTH     = 64;
  localparam int TAG_WIDTH      = 8;
  localparam int CONCAT_WIDTH   = TAG_WIDTH + 2 + DATA_WIDTH;
  localparam int PNODE_WIDTH    = 74;
  localparam int INFLIGHT_WIDTH = 9;
  localparam int ERR_WIDTH      = 16;

  // Bit positions inside the outgoing pnode word {tag, sop, eop, data}
  localparam int PNODE_DATA_LSB = 0;
  localparam int PNODE_EOP_BIT  = 64;
  localparam int PNODE_SOP_BIT  = 65;
  localparam int PNODE_TAG_LSB  = 66;
  localparam int PNODE_TAG_MSB  = 73;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_INPKT = 1'b1
  } pktState_t;

  function automatic logic [PNODE_WIDTH-1:0] packPnode(
    input logic [TAG_WIDTH-1:0]  tag,
    input logic                  sop,
    input logic                  eop,
    input logic [DATA_WIDTH-1:0] data
  );
    return {tag, sop, eop, data};
  endfunction

  // Error counter sticks at all-ones instead of wrapping
  function automatic logic [ERR_WIDTH-1:0] satAddErr(
    input logic [ERR_WIDTH-1:0] count,
    input logic [1:0]           inc
  );
    logic [ERR_WIDTH:0] sum;
    sum = {1'b0, count} + {{(ERR_WIDTH-1){1'b0}}, inc};
    return sum[ERR_WIDTH] ? {ERR_WIDTH{1'b1}} : sum[ERR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pnode_skidbuf.sv
// Small FIFO whose head sits in a registered output stage; DEPTH counts the
// output register plus the DEPTH-1 storage entries behind it.
module pnode_skidbuf #(
  parameter int WIDTH = 74,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_pushValid,
  input  logic [WIDTH-1:0] i_pushData,
  output logic             o_hasSpace,
  output logic             o_outValid,
  output logic [WIDTH-1:0] o_outData,
  input  logic             i_outReady
);

  localparam int FIFO_DEPTH = DEPTH - 1;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_fifoCount;
  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;

  logic w_pop;
  logic w_outFree;
  logic w_fifoEmpty;
  logic w_pushToOut;
  logic w_pushToFifo;
  logic w_fifoPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign w_pop        = r_outValid && i_outReady;
  assign w_outFree    = !r_outValid || w_pop;
  assign w_fifoEmpty  = (r_fifoCount == '0);
  assign w_pushToOut  = i_pushValid && w_outFree && w_fifoEmpty;
  assign w_pushToFifo = i_pushValid && !w_pushToOut;
  assign w_fifoPop    = w_outFree && !w_fifoEmpty;

  // Space is judged on current occupancy only, so rx_ready never depends on pnode_ready
  assign o_hasSpace = ({{(CNT_W-1){1'b0}}, r_outValid} + r_fifoCount) < CNT_W'(DEPTH);
  assign o_outValid = r_outValid;
  assign o_outData  = r_outData;

  always_ff @(posedge clock) begin
    if (w_pushToFifo) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_fifoCount <= '0;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
    end else begin
      if (w_outFree) begin
        if (!w_fifoEmpty) begin
          r_outValid <= 1'b1;
          r_outData  <= r_mem[r_rdPtr];
        end else if (i_pushValid) begin
          r_outValid <= 1'b1;
          r_outData  <= i_pushData;
        end else begin
          r_outValid <= 1'b0;
        end
      end
      if (w_pushToFifo) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_fifoPop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      case ({w_pushToFifo, w_fifoPop})
        2'b10:   r_fifoCount <= r_fifoCount + 1'b1;
        2'b01:   r_fifoCount <= r_fifoCount - 1'b1;
        default: r_fifoCount <= r_fifoCount;
      endcase
    end
  end

endmodule

// File: rtl/pnode_tagger.sv
// Tags each Avalon-ST packet with an 8-bit id taken at SOP, drops malformed
// beats, tracks outstanding tags and forwards beats through a skid buffer.
module pnode_tagger
  import pnode_tagger_pkg::*;
#(
  parameter int MAX_INFLIGHT = 64,
  parameter int SKID_DEPTH   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     avalon_st_rx_data,
  input  logic                      avalon_st_rx_sop,
  input  logic                      avalon_st_rx_eop,
  input  logic                      avalon_st_rx_valid,
  input  logic [2:0]                avalon_st_rx_empty,
  input  logic [5:0]                avalon_st_rx_error,
  output logic                      avalon_st_rx_ready,
  output logic [PNODE_WIDTH-1:0]    pnode_data,
  output logic                      pnode_valid,
  input  logic                      pnode_ready,
  input  logic                      tag_release_valid,
  input  logic [TAG_WIDTH-1:0]      tag_release,
  output logic [INFLIGHT_WIDTH-1:0] inflight_count,
  output logic [ERR_WIDTH-1:0]      proto_err_count
);

  localparam logic [INFLIGHT_WIDTH-1:0] MAX_INFL = INFLIGHT_WIDTH'(MAX_INFLIGHT);

  pktState_t                 r_state;
  logic [TAG_WIDTH-1:0]      r_tagCtr;
  logic [TAG_WIDTH-1:0]      r_curTag;
  logic [INFLIGHT_WIDTH-1:0] r_inflight;
  logic [ERR_WIDTH-1:0]      r_errCount;
  logic                      r_active;

  logic                   w_hasSpace;
  logic                   w_fire;
  logic                   w_allocate;
  logic                   w_dropBeat;
  logic                   w_push;
  logic [TAG_WIDTH-1:0]   w_pushTag;
  logic [PNODE_WIDTH-1:0] w_pushData;
  logic                   w_releaseOk;
  logic                   w_releaseBad;
  logic [1:0]             w_errInc;
  logic                   w_unusedInputs;

  // Framing side-band and the released tag value are accepted but carry no meaning here
  assign w_unusedInputs = ^{avalon_st_rx_empty, avalon_st_rx_error, tag_release};

  assign avalon_st_rx_ready = r_active && w_hasSpace &&
                              ((r_state == ST_INPKT) || (r_inflight < MAX_INFL));

  assign w_fire       = avalon_st_rx_valid && avalon_st_rx_ready;
  assign w_allocate   = w_fire && (r_state == ST_IDLE) && avalon_st_rx_sop;
  assign w_dropBeat   = w_fire && (((r_state == ST_IDLE)  && !avalon_st_rx_sop) ||
                                   ((r_state == ST_INPKT) &&  avalon_st_rx_sop));
  assign w_push       = w_fire && !w_dropBeat;
  assign w_pushTag    = (r_state == ST_IDLE) ? r_tagCtr : r_curTag;
  assign w_pushData   = packPnode(w_pushTag, avalon_st_rx_sop, avalon_st_rx_eop,
                                  avalon_st_rx_data);
  assign w_releaseOk  = tag_release_valid && (r_inflight != '0);
  assign w_releaseBad = tag_release_valid && (r_inflight == '0);
  assign w_errInc     = {1'b0, w_dropBeat} + {1'b0, w_releaseBad};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tagCtr   <= '0;
      r_curTag   <= '0;
      r_inflight <= '0;
      r_errCount <= '0;
      r_active   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_allocate) begin
            r_tagCtr <= r_tagCtr + 1'b1;
            if (!avalon_st_rx_eop) begin
              r_curTag <= r_tagCtr;
              r_state  <= ST_INPKT;
            end
          end
        end
        ST_INPKT: begin
          if (w_push && avalon_st_rx_eop) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Allocation and release in the same cycle cancel out
      if (w_allocate && !w_releaseOk) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_allocate && w_releaseOk) begin
        r_inflight <= r_inflight - 1'b1;
      end
      r_errCount <= satAddErr(r_errCount, w_errInc);
    end
  end

  assign inflight_count  = r_inflight;
  assign proto_err_count = r_errCount;

  pnode_skidbuf #(
    .WIDTH (PNODE_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skidbuf (
    .clock       (clock),
    .reset       (reset),
    .i_pushValid (w_push),
    .i_pushData  (w_pushData),
    .o_hasSpace  (w_hasSpace),
    .o_outValid  (pnode_valid),
    .o_outData   (pnode_data),
    .i_outReady  (pnode_ready)
  );

endmodule

// File: tb/tb_pnode_tagger.sv
// Self-checking bench for pnode_tagger: directed scenarios plus random traffic,
// all compared against a queue-based packet/tag model.
module tb_pnode_tagger;

  localparam int MAX_INFL = 4;
  localparam int SKID     = 2;

  logic        clock;
  logic        reset;
  logic [63:0] avalon_st_rx_data;
  logic        avalon_st_rx_sop;
  logic        avalon_st_rx_eop;
  logic        avalon_st_rx_valid;
  logic [2:0]  avalon_st_rx_empty;
  logic [5:0]  avalon_st_rx_error;
  logic        avalon_st_rx_ready;
  logic [73:0] pnode_data;
  logic        pnode_valid;
  logic        pnode_ready;
  logic        tag_release_valid;
  logic [7:0]  tag_release;
  logic [8:0]  inflight_count;
  logic [15:0] proto_err_count;

  pnode_tagger #(
    .MAX_INFLIGHT (MAX_INFL),
    .SKID_DEPTH   (SKID)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .avalon_st_rx_data  (avalon_st_rx_data),
    .avalon_st_rx_sop   (avalon_st_rx_sop),
    .avalon_st_rx_eop   (avalon_st_rx_eop),
    .avalon_st_rx_valid (avalon_st_rx_valid),
    .avalon_st_rx_empty (avalon_st_rx_empty),
    .avalon_st_rx_error (avalon_st_rx_error),
    .avalon_st_rx_ready (avalon_st_rx_ready),
    .pnode_data         (pnode_data),
    .pnode_valid        (pnode_valid),
    .pnode_ready        (pnode_ready),
    .tag_release_valid  (tag_release_valid),
    .tag_release        (tag_release),
    .inflight_count     (inflight_count),
    .proto_err_count    (proto_err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectorCount     = 0;
  int miscompareCount = 0;
  int cycleCount      = 0;

  // Reference model: expected output beats in order, packet/tag bookkeeping
  logic [73:0] mQ[$];
  bit          mInPkt;
  int          mTag;
  int          mCurTag;
  int          mInflight;
  int          mErr;
  bit          mActive;
  bit          mAccepted;

  task automatic checkOutput(input string tag, input logic [73:0] actual,
                             input logic [73:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  function automatic bit modelReady();
    return mActive && (mQ.size() < SKID) && (mInPkt || (mInflight < MAX_INFL));
  endfunction

  // One cycle: check outputs against the model, drive inputs, advance the model
  task automatic applyStimulus(input bit v, input bit sop, input bit eop,
                               input logic [63:0] d, input bit relV,
                               input logic [7:0] relTag, input bit pr);
    bit expReady;
    int errInc;
    bit alloc;
    bit rel;
    @(negedge clock);
    cycleCount++;
    expReady = modelReady();
    checkOutput("rx_ready", avalon_st_rx_ready, expReady);
    checkOutput("pnode_valid", pnode_valid, mQ.size() > 0);
    if (mQ.size() > 0) checkOutput("pnode_data", pnode_data, mQ[0]);
    checkOutput("inflight", inflight_count, mInflight);
    checkOutput("proto_err", proto_err_count, mErr);
    avalon_st_rx_valid = v;
    avalon_st_rx_sop   = sop;
    avalon_st_rx_eop   = eop;
    avalon_st_rx_data  = d;
    avalon_st_rx_empty = 3'($urandom);
    avalon_st_rx_error = 6'($urandom);
    tag_release_valid  = relV;
    tag_release        = relTag;
    pnode_ready        = pr;
    mAccepted = v && expReady;
    if (pr && mQ.size() > 0) void'(mQ.pop_front());
    errInc = 0;
    alloc  = 0;
    rel    = 0;
    if (mAccepted) begin
      if (!mInPkt) begin
        if (sop) begin
          mQ.push_back({mTag[7:0], sop, eop, d});
          alloc = 1;
          if (!eop) begin
            mInPkt  = 1;
            mCurTag = mTag;
          end
          mTag = (mTag + 1) % 256;
        end else begin
          errInc++;
        end
      end else begin
        if (sop) begin
          errInc++;
        end else begin
          mQ.push_back({mCurTag[7:0], sop, eop, d});
          if (eop) mInPkt = 0;
        end
      end
    end
    if (relV) begin
      if (mInflight == 0) errInc++;
      else rel = 1;
    end
    mInflight = mInflight + int'(alloc) - int'(rel);
    mErr      = (mErr + errInc > 65535) ? 65535 : mErr + errInc;
    mActive   = 1;
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset              = 1'b1;
    avalon_st_rx_valid = 1'b0;
    avalon_st_rx_sop   = 1'b0;
    avalon_st_rx_eop   = 1'b0;
    tag_release_valid  = 1'b0;
    pnode_ready        = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_pnode_valid", pnode_valid, 1'b0);
    checkOutput("reset_pnode_data", pnode_data, 74'd0);
    checkOutput("reset_rx_ready", avalon_st_rx_ready, 1'b0);
    checkOutput("reset_inflight", inflight_count, 9'd0);
    checkOutput("reset_proto_err", proto_err_count, 16'd0);
    reset = 1'b0;
    mQ.delete();
    mInPkt    = 0;
    mTag      = 0;
    mCurTag   = 0;
    mInflight = 0;
    mErr      = 0;
    mActive   = 1;
  endtask

  task automatic sendBeat(input bit sop, input bit eop, input bit pr);
    int budget;
    budget = 0;
    do begin
      applyStimulus(1'b1, sop, eop, {$urandom, $urandom}, 1'b0, 8'd0, pr);
      budget++;
    end while (!mAccepted && budget < 64);
    if (!mAccepted) checkOutput("send_timeout", mAccepted, 1'b1);
  endtask

  task automatic idleCycles(input int n, input bit pr);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 8'd0, pr);
  endtask

  task automatic releaseTags(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 8'($urandom), 1'b1);
  endtask

  initial begin
    int startCycle;
    int idx;
    int guard;
    reset              = 1'b1;
    avalon_st_rx_data  = '0;
    avalon_st_rx_sop   = 1'b0;
    avalon_st_rx_eop   = 1'b0;
    avalon_st_rx_valid = 1'b0;
    avalon_st_rx_empty = '0;
    avalon_st_rx_error = '0;
    pnode_ready        = 1'b0;
    tag_release_valid  = 1'b0;
    tag_release        = '0;
    mActive            = 0;

    resetDut();

    // Three 4-beat packets back to back: tags 0,1,2 at one beat per cycle
    startCycle = cycleCount;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++) sendBeat(b == 0, b == 3, 1'b1);
    checkOutput("stream_cycles", cycleCount - startCycle, 12);
    idleCycles(3, 1'b1);
    checkOutput("inflight_3pkts", inflight_count, 9'd3);
    releaseTags(3);

    // Release and SOP together at inflight 1 leaves the count at 1
    sendBeat(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 8'd3, 1'b1);
    idleCycles(1, 1'b1);
    checkOutput("same_cycle_release", inflight_count, 9'd1);
    releaseTags(1);

    // Fill every tag slot, the next SOP must stall until a release
    for (int i = 0; i < MAX_INFL; i++) sendBeat(1'b1, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b1, {$urandom, $urandom}, 1'b0, 8'd0, 1'b1);
    checkOutput("stall_ready", avalon_st_rx_ready, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 8'd5, 1'b1);
    sendBeat(1'b1, 1'b1, 1'b1);
    idleCycles(1, 1'b1);
    checkOutput("stall_tag", pnode_data[73:66], 8'd9);
    releaseTags(MAX_INFL);

    // Beat without SOP in IDLE, then SOP inside a packet: both dropped
    applyStimulus(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, 1'b0, 8'd0, 1'b1);
    sendBeat(1'b1, 1'b0, 1'b1);
    sendBeat(1'b1, 1'b0, 1'b1);
    sendBeat(1'b0, 1'b1, 1'b1);
    idleCycles(3, 1'b1);
    checkOutput("proto_err_drops", proto_err_count, 16'd2);
    releaseTags(1);

    // Downstream back-pressure for 10 cycles in the middle of a 6-beat packet
    idx   = 0;
    guard = 0;
    while (idx < 6 && guard < 100) begin
      applyStimulus(1'b1, idx == 0, idx == 5, {$urandom, $urandom}, 1'b0, 8'd0,
                    (guard < 2 || guard >= 12));
      if (mAccepted) idx++;
      guard++;
    end
    checkOutput("backpressure_done", idx, 6);
    idleCycles(4, 1'b1);
    releaseTags(1);

    // 256 single-beat packets with immediate releases force a tag wrap
    for (int p = 0; p < 256; p++) begin
      guard = 0;
      do begin
        applyStimulus(1'b1, 1'b1, 1'b1, {$urandom, $urandom}, mInflight > 0, 8'd0, 1'b1);
        guard++;
      end while (!mAccepted && guard < 64);
      if (!mAccepted) checkOutput("wrap_timeout", mAccepted, 1'b1);
    end
    idleCycles(2, 1'b1);

    // Reset in the middle of a buffered packet discards it; tags restart at 0
    sendBeat(1'b1, 1'b0, 1'b0);
    sendBeat(1'b0, 1'b0, 1'b0);
    resetDut();
    sendBeat(1'b1, 1'b1, 1'b1);
    idleCycles(1, 1'b1);
    checkOutput("tag_after_reset", pnode_data[73:66], 8'd0);
    releaseTags(2);
    idleCycles(1, 1'b1);

    // Random traffic with malformed framing, bogus releases and back-pressure
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      bit sop;
      bit eop;
      sop = ($urandom_range(0, 7) == 0) ? 1'($urandom) : !mInPkt;
      eop = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 3) != 0, sop, eop, {$urandom, $urandom},
                    $urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    idleCycles(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
